packed_cel_row_decoder: RTL and testbench

- Downstream consumer and controller of the bitreader in the MADAM path.
- Walks a 3DO-style packed CEL: per row it issues ATTACH/READ commands to the bitreader, parses the row offset and the packet headers, and expands them into a pixel stream.
- The pixel stream (valid/ready) feeds the pixel pipeline.
- Provides start/busy/done control for the CEL engine.

---
 rtl/packed_cel_row_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_packed_cel_row_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_cel_row_decoder.sv
// Packed CEL row walker: drives the bitreader, parses row offsets and packet headers, emits pixels.
// Optional PACKED_ROW_PAD_EN: pad short rows with transparent pixels up to row_width.
package bitreader_pkg;
  typedef enum logic [1:0] {BR_ATTACH = 2'd0, BR_SKIP = 2'd1, BR_READ = 2'd2} bitreader_op_e;
endpackage

module packed_cel_row_decoder
  import bitreader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PIX_WIDTH  = 16,
  parameter int WIDTH_BITS = 11,
  parameter int ROWS_BITS  = 11
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cel_addr,
  input  logic [4:0]            bpp,
  input  logic [WIDTH_BITS-1:0] row_width,
  input  logic [ROWS_BITS-1:0]  row_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  br_req,
  output bitreader_op_e         br_op,
  output logic [ADDR_WIDTH-1:0] br_addr,
  output logic [DATA_WIDTH-1:0] br_bitrate,
  output logic [DATA_WIDTH-1:0] br_bitskip,
  input  logic                  br_busy,
  input  logic [DATA_WIDTH-1:0] br_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_transp,
  output logic                  row_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ATTACH, S_OFFSET, S_HDR, S_PIXRD, S_EMIT, S_PAD, S_ROWEND, S_DONE
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next_addr;
  logic [4:0]            r_bpp;
  logic [WIDTH_BITS-1:0] r_width, r_col;
  logic [ROWS_BITS-1:0]  r_rows;
  logic [6:0]            r_remaining;
  logic [1:0]            r_type;
  logic                  r_wait, r_busy_seen;
  logic                  r_busy, r_done, r_error, r_br_req, r_row_done;
  bitreader_op_e         r_br_op;
  logic [ADDR_WIDTH-1:0] r_br_addr;
  logic [DATA_WIDTH-1:0] r_br_bitrate;
  logic                  r_pix_valid, r_pix_transp;
  logic [PIX_WIDTH-1:0]  r_pix_data;

  logic                  w_bpp_legal, w_cmd_state, w_cmd_done, w_col_fits;
  bitreader_op_e         w_cmd_op;
  logic [DATA_WIDTH-1:0] w_cmd_rate;
  logic [9:0]            w_offset;
  logic [ADDR_WIDTH-1:0] w_row_step;
  logic [PIX_WIDTH-1:0]  w_pix_mask, w_pix;
  logic [6:0]            w_hdr_n;
  logic [WIDTH_BITS-1:0] w_col_inc, w_col_next;
  logic                  w_unused;

  assign w_bpp_legal = (r_bpp == 5'd1) || (r_bpp == 5'd2) || (r_bpp == 5'd4) ||
                       (r_bpp == 5'd6) || (r_bpp == 5'd8) || (r_bpp == 5'd16);
  assign w_cmd_state = (r_state == S_ATTACH) || (r_state == S_OFFSET) ||
                       (r_state == S_HDR) || (r_state == S_PIXRD);
  assign w_cmd_op    = (r_state == S_ATTACH) ? BR_ATTACH : BR_READ;
  // A command only completes once the bitreader has been seen busy and then idle again.
  assign w_cmd_done  = r_wait && r_busy_seen && !br_busy;
  assign w_offset    = (r_bpp < 5'd8) ? {2'b00, br_data[7:0]} : br_data[9:0];
  assign w_row_step  = (ADDR_WIDTH'(w_offset) + ADDR_WIDTH'(2)) << 2;
  assign w_pix_mask  = ~({PIX_WIDTH{1'b1}} << r_bpp);
  assign w_pix       = br_data[PIX_WIDTH-1:0] & w_pix_mask;
  assign w_hdr_n     = 7'(br_data[5:0]) + 7'd1;
  assign w_col_fits  = r_col < r_width;
  assign w_col_inc   = r_col + WIDTH_BITS'(1);
  assign w_col_next  = r_pix_valid ? w_col_inc : r_col;
  assign w_unused    = ^br_data[DATA_WIDTH-1:PIX_WIDTH];

  always_comb begin
    w_cmd_rate = '0;
    case (r_state)
      S_OFFSET: w_cmd_rate = (r_bpp < 5'd8) ? DATA_WIDTH'(8) : DATA_WIDTH'(16);
      S_HDR:    w_cmd_rate = DATA_WIDTH'(8);
      S_PIXRD:  w_cmd_rate = DATA_WIDTH'(r_bpp);
      default:  w_cmd_rate = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_next_addr  <= '0;
      r_bpp        <= '0;
      r_width      <= '0;
      r_col        <= '0;
      r_rows       <= '0;
      r_remaining  <= '0;
      r_type       <= '0;
      r_wait       <= 1'b0;
      r_busy_seen  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_br_req     <= 1'b0;
      r_br_op      <= BR_ATTACH;
      r_br_addr    <= '0;
      r_br_bitrate <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_transp <= 1'b0;
      r_pix_data   <= '0;
      r_row_done   <= 1'b0;
    end else begin
      r_br_req   <= 1'b0;
      r_done     <= 1'b0;
      r_row_done <= 1'b0;
      if (r_wait && br_busy) r_busy_seen <= 1'b1;
      if (w_cmd_state && !r_wait) begin
        r_br_req     <= 1'b1;
        r_br_op      <= w_cmd_op;
        r_br_bitrate <= w_cmd_rate;
        if (r_state == S_ATTACH) r_br_addr <= r_addr;
        r_wait       <= 1'b1;
        r_busy_seen  <= 1'b0;
      end
      if (w_cmd_done) r_wait <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_addr  <= cel_addr;
            r_bpp   <= bpp;
            r_width <= row_width;
            r_rows  <= row_count;
            r_col   <= '0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!w_bpp_legal) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else if (r_rows == '0) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_ATTACH;
          end
        end
        S_ATTACH: if (w_cmd_done) r_state <= S_OFFSET;
        S_OFFSET: begin
          if (w_cmd_done) begin
            r_next_addr <= r_addr + w_row_step;
            r_state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_cmd_done) begin
            r_type      <= br_data[7:6];
            r_remaining <= w_hdr_n;
            case (br_data[7:6])
              2'd0: r_state <= S_PAD;
              2'd2: begin
                r_pix_data   <= '0;
                r_pix_transp <= 1'b1;
                r_pix_valid  <= w_col_fits;
                r_state      <= S_EMIT;
              end
              default: r_state <= S_PIXRD;
            endcase
          end
        end
        S_PIXRD: begin
          if (w_cmd_done) begin
            r_pix_data   <= w_pix;
            r_pix_transp <= 1'b0;
            r_pix_valid  <= w_col_fits;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          // A clipped pixel (valid low) is consumed silently to keep the stream position.
          if (!(r_pix_valid && !pix_ready)) begin
            r_col       <= w_col_next;
            r_remaining <= r_remaining - 7'd1;
            if (r_remaining == 7'd1) begin
              r_pix_valid <= 1'b0;
              r_state     <= S_HDR;
            end else if (r_type == 2'd1) begin
              r_pix_valid <= 1'b0;
              r_state     <= S_PIXRD;
            end else begin
              r_pix_valid <= w_col_next < r_width;
            end
          end
        end
        S_PAD: begin
`ifdef PACKED_ROW_PAD_EN
          if (r_pix_valid) begin
            if (pix_ready) begin
              r_col       <= w_col_inc;
              r_pix_valid <= w_col_inc < r_width;
            end
          end else if (w_col_fits) begin
            r_pix_valid  <= 1'b1;
            r_pix_data   <= '0;
            r_pix_transp <= 1'b1;
          end else begin
            r_state <= S_ROWEND;
          end
`else
          r_state <= S_ROWEND;
`endif
        end
        S_ROWEND: begin
          r_row_done <= 1'b1;
          r_addr     <= r_next_addr;
          r_rows     <= r_rows - ROWS_BITS'(1);
          r_col      <= '0;
          r_state    <= (r_rows == ROWS_BITS'(1)) ? S_DONE : S_ATTACH;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign br_req     = r_br_req;
  assign br_op      = r_br_op;
  assign br_addr    = r_br_addr;
  assign br_bitrate = r_br_bitrate;
  assign br_bitskip = '0;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_transp = r_pix_transp;
  assign row_done   = r_row_done;

endmodule

// File: tb/tb_packed_cel_row_decoder.sv
// Scoreboard bench for packed_cel_row_decoder with a behavioural bitreader responder.
module tb_packed_cel_row_decoder;
  import bitreader_pkg::*;

  logic        aclk, areset, start;
  logic [31:0] cel_addr;
  logic [4:0]  bpp;
  logic [10:0] row_width, row_count;
  logic        busy, done, error, br_req, br_busy;
  bitreader_op_e br_op;
  logic [31:0] br_addr, br_bitrate, br_bitskip, br_data;
  logic        pix_valid, pix_ready, pix_transp, row_done;
  logic [15:0] pix_data;

  packed_cel_row_decoder dut (
    .aclk(aclk), .areset(areset), .start(start), .cel_addr(cel_addr), .bpp(bpp),
    .row_width(row_width), .row_count(row_count), .busy(busy), .done(done), .error(error),
    .br_req(br_req), .br_op(br_op), .br_addr(br_addr), .br_bitrate(br_bitrate),
    .br_bitskip(br_bitskip), .br_busy(br_busy), .br_data(br_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_transp(pix_transp), .row_done(row_done)
  );

  typedef struct { int rate; logic [31:0] data; } rd_t;
  rd_t         rd_q[$];
  logic [31:0] att_q[$];
  logic [16:0] px_q[$];

  int n_chk = 0, n_pass = 0;
  int n_req = 0, n_att = 0, n_rd = 0, n_rowdone = 0, n_done = 0;
  int br_cnt = 0;
  logic [31:0] pending = 0;
  bit stall_arm = 0, hold_ready = 0, prev_stall = 0;
  logic [16:0] prev_px = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  // Bitreader responder: busy for two cycles per command, then presents read data.
  initial begin
    br_busy = 0;
    br_data = 0;
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        br_busy = 0;
        br_cnt = 0;
      end else begin
        if (br_cnt > 0) begin
          br_cnt--;
          if (br_cnt == 0) begin
            br_busy = 0;
            br_data = pending;
          end
        end
        if (br_req) begin
          n_req++;
          br_busy = 1;
          br_cnt = 2;
          chk("br_bitskip", br_bitskip, 0);
          case (br_op)
            BR_ATTACH: begin
              n_att++;
              chk("attach_expected", att_q.size() != 0, 1);
              if (att_q.size() != 0) chk("attach_addr", br_addr, att_q.pop_front());
            end
            BR_READ: begin
              n_rd++;
              chk("read_expected", rd_q.size() != 0, 1);
              if (rd_q.size() != 0) begin
                rd_t e;
                e = rd_q.pop_front();
                chk("read_bitrate", br_bitrate, e.rate);
                pending = e.data;
              end
            end
            default: chk("br_op", br_op, BR_READ);
          endcase
        end
      end
    end
  end

  // Consumer ready: normally high; optional 5-cycle stall on the first presented pixel.
  initial begin
    pix_ready = 1;
    forever begin
      @(posedge aclk); #2;
      if (hold_ready) pix_ready = 0;
      else if (stall_arm && pix_valid) begin
        int snap;
        pix_ready = 0;
        stall_arm = 0;
        snap = n_req;
        repeat (5) @(posedge aclk);
        #2;
        chk("stall_no_br_req", n_req, snap);
        chk("stall_valid_held", pix_valid, 1);
        pix_ready = 1;
      end else pix_ready = 1;
    end
  end

  // Monitor: pops the scoreboard on every accepted pixel and checks stall stability.
  initial begin
    forever begin
      @(negedge aclk);
      if (prev_stall) chk("stall_hold", {pix_valid, pix_transp, pix_data}, {1'b1, prev_px});
      if (!areset && pix_valid && pix_ready) begin
        chk("pixel_expected", px_q.size() != 0, 1);
        if (px_q.size() != 0) chk("pixel", {pix_transp, pix_data}, px_q.pop_front());
      end
      if (row_done) n_rowdone++;
      if (done) n_done++;
      prev_stall = !areset && pix_valid && !pix_ready;
      prev_px = {pix_transp, pix_data};
    end
  end

  task automatic push_rd(input int rate, input logic [31:0] d);
    rd_t e;
    e.rate = rate;
    e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic push_px(input logic [15:0] d);
    px_q.push_back({1'b0, d});
  endtask

  task automatic push_tr(input int n);
    for (int i = 0; i < n; i++) px_q.push_back({1'b1, 16'h0});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, error, br_req, pix_valid, pix_transp, row_done, br_op}, 0);
    chk({tag, "_br_addr"}, br_addr, 0);
    chk({tag, "_bitrate"}, br_bitrate, 0);
    chk({tag, "_bitskip"}, br_bitskip, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
  endtask

  task automatic run_cel(input logic [31:0] a, input logic [4:0] b, input logic [10:0] w,
                         input logic [10:0] r, input int e_att, input int e_rd,
                         input int e_rows, input logic e_err);
    int att0, rd0, rows0, done0;
    bit seen;
    att0 = n_att; rd0 = n_rd; rows0 = n_rowdone; done0 = n_done;
    @(negedge aclk);
    cel_addr = a; bpp = b; row_width = w; row_count = r; start = 1;
    @(negedge aclk);
    start = 0;
    chk("busy_after_start", busy, 1);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge aclk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    @(negedge aclk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_count", n_done - done0, 1);
    chk("error", error, e_err);
    chk("attach_count", n_att - att0, e_att);
    chk("read_count", n_rd - rd0, e_rd);
    chk("row_done_count", n_rowdone - rows0, e_rows);
    chk("pixels_left", px_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("attach_left", att_q.size(), 0);
  endtask

  initial begin
    bit seen;
    areset = 1; start = 0; cel_addr = 0; bpp = 0; row_width = 0; row_count = 0;
    repeat (3) @(negedge aclk);
    check_zero("reset");
    areset = 0;

    // Literal row: offset, hdr 0x42, three pixels, EOL
    att_q.push_back(32'h100);
    push_rd(16, 0); push_rd(8, 32'h42); push_rd(8, 32'h11); push_rd(8, 32'h22);
    push_rd(8, 32'h33); push_rd(8, 0);
    push_px(16'h11); push_px(16'h22); push_px(16'h33);
`ifdef PACKED_ROW_PAD_EN
    push_tr(1);
`endif
    run_cel(32'h100, 5'd8, 11'd4, 11'd1, 1, 6, 1, 0);

    // Packed 0xC3 (value 0x7A x4) then transparent 0x81 (x2)
    att_q.push_back(32'h200);
    push_rd(16, 0); push_rd(8, 32'hC3); push_rd(8, 32'h7A); push_rd(8, 32'h81); push_rd(8, 0);
    for (int i = 0; i < 4; i++) push_px(16'h7A);
    push_tr(2);
`ifdef PACKED_ROW_PAD_EN
    push_tr(2);
`endif
    run_cel(32'h200, 5'd8, 11'd8, 11'd1, 1, 5, 1, 0);

    // Two rows, offset 1 moves the second attach to +12 bytes
    att_q.push_back(32'h271BD0); att_q.push_back(32'h271BDC);
    push_rd(16, 1); push_rd(8, 32'h40); push_rd(8, 32'hAA); push_rd(8, 0);
    push_rd(16, 0); push_rd(8, 32'h80); push_rd(8, 0);
    push_px(16'hAA);
`ifdef PACKED_ROW_PAD_EN
    push_tr(3);
`endif
    push_tr(1);
`ifdef PACKED_ROW_PAD_EN
    push_tr(3);
`endif
    run_cel(32'h271BD0, 5'd8, 11'd4, 11'd2, 2, 7, 2, 0);

    // Clip at width 2: third literal pixel read but not presented
    att_q.push_back(32'h300);
    push_rd(16, 0); push_rd(8, 32'h42); push_rd(8, 1); push_rd(8, 2); push_rd(8, 3); push_rd(8, 0);
    push_px(16'h1); push_px(16'h2);
    run_cel(32'h300, 5'd8, 11'd2, 11'd1, 1, 6, 1, 0);

    // Same row at width 5
    att_q.push_back(32'h400);
    push_rd(16, 0); push_rd(8, 32'h42); push_rd(8, 1); push_rd(8, 2); push_rd(8, 3); push_rd(8, 0);
    push_px(16'h1); push_px(16'h2); push_px(16'h3);
`ifdef PACKED_ROW_PAD_EN
    push_tr(2);
`endif
    run_cel(32'h400, 5'd8, 11'd5, 11'd1, 1, 6, 1, 0);

    // 4bpp with masking and a 5-cycle consumer stall
    att_q.push_back(32'h500);
    push_rd(8, 0); push_rd(8, 32'h41); push_rd(4, 32'hF5); push_rd(4, 32'h3C); push_rd(8, 0);
    push_px(16'h5); push_px(16'hC);
`ifdef PACKED_ROW_PAD_EN
    push_tr(2);
`endif
    stall_arm = 1;
    run_cel(32'h500, 5'd4, 11'd4, 11'd1, 1, 5, 1, 0);
    chk("stall_happened", stall_arm, 0);

    // 16bpp: 10-bit offset field, full-width pixel
    att_q.push_back(32'h1000); att_q.push_back(32'h101C);
    push_rd(16, 32'hFC05); push_rd(8, 32'hC0); push_rd(16, 32'h1ABCD); push_rd(8, 0);
    push_rd(16, 0); push_rd(8, 0);
    push_px(16'hABCD);
`ifdef PACKED_ROW_PAD_EN
    push_tr(3);
`endif
    run_cel(32'h1000, 5'd16, 11'd2, 11'd2, 2, 6, 2, 0);

    // Illegal bpp, then zero rows (error cleared by the new start)
    run_cel(32'h600, 5'd3, 11'd4, 11'd1, 0, 0, 0, 1);
    run_cel(32'h700, 5'd8, 11'd4, 11'd0, 0, 0, 0, 0);

    // Reset while a pixel is waiting for the consumer
    hold_ready = 1;
    att_q.push_back(32'h800);
    push_rd(16, 0); push_rd(8, 32'h40); push_rd(8, 32'h55);
    @(negedge aclk);
    cel_addr = 32'h800; bpp = 5'd8; row_width = 11'd4; row_count = 11'd3; start = 1;
    @(negedge aclk);
    start = 0;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge aclk);
      if (pix_valid) seen = 1;
    end
    chk("reset_test_valid_seen", seen, 1);
    @(posedge aclk); #2;
    areset = 1;
    @(negedge aclk);
    @(negedge aclk);
    check_zero("midrun_reset");
    areset = 0;
    hold_ready = 0;
    rd_q.delete(); att_q.delete(); px_q.delete();
    run_cel(32'h900, 5'd8, 11'd4, 11'd0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
